// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder step per clock, LSB first,
// with a start/busy/done handshake toward the ALU result bus.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
    logic             carry_q, carry_d, c_msb_q, c_msb_d;
    logic             co_q, co_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c, last_bit;

    assign fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_c     = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        c_msb_d = c_msb_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1, so the +1 rides in as carry.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : ci;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_c;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 2)) c_msb_d = fa_c;
                if (last_bit) begin
                    sum_d = {fa_s, res_q[WIDTH-1:1]};
                    co_d  = fa_c;
                    ovf_d = c_msb_q ^ fa_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            c_msb_q <= c_msb_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum = sum_q;
    assign co  = co_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: arithmetic reference model checked every cycle,
// plus directed cases with hand-computed results.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         busy, done, co, ovf;
    logic [W-1:0] sum;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int dn_cnt = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .sum(sum), .co(co), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: an accepted op completes W edges later.
    logic         m_busy = 0, m_done = 0, m_co = 0, m_ovf = 0;
    logic [W-1:0] m_sum = '0;
    logic [W-1:0] p_sum;
    logic         p_co, p_ovf;
    int           m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_sum = '0;
            m_co = 0; m_ovf = 0; m_left = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1;
                m_sum = p_sum; m_co = p_co; m_ovf = p_ovf;
            end
        end else if (start) begin
            logic [W-1:0] eb;
            logic [W:0]   full;
            eb    = sub ? ~b : b;
            full  = {1'b0, a} + {1'b0, eb} + (W+1)'(sub ? 1'b1 : ci);
            p_sum = full[W-1:0];
            p_co  = full[W];
            p_ovf = (a[W-1] == eb[W-1]) && (p_sum[W-1] != a[W-1]);
            m_busy = 1;
            m_left = W;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) dn_cnt++;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("sum", 32'(sum), 32'(m_sum));
        chk("co", 32'(co), 32'(m_co));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    end

    task automatic wait_done(output int k);
        bit seen = 0;
        for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ici, input logic isub,
                         input logic [W-1:0] es, input logic eco,
                         input logic eov, input string name);
        int k;
        a = ia; b = ib; ci = ici; sub = isub; start = 1;
        @(negedge clk);
        start = 0;
        wait_done(k);
        chk({name, "_lat"}, 32'(k), 32'(W));
        chk({name, "_sum"}, 32'(sum), 32'(es));
        chk({name, "_co"}, 32'(co), 32'(eco));
        chk({name, "_ovf"}, 32'(ovf), 32'(eov));
        @(negedge clk);
    endtask

    initial begin
        int k, c1, d0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sum", 32'(sum), 0);
        rst_n = 1;
        @(negedge clk);

        do_op(8'h5A, 8'h3C, 0, 0, 8'h96, 0, 1, "add");
        do_op(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, "wrap");
        do_op(8'h00, 8'h00, 1, 0, 8'h01, 0, 0, "cin");
        do_op(8'h10, 8'h20, 1, 1, 8'hF0, 0, 0, "sub1");
        do_op(8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, "sub2");

        // Busy protection: second start in the 3rd SHIFT cycle
        d0 = dn_cnt;
        a = 8'h5A; b = 8'h3C; ci = 0; sub = 0; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1;
        @(negedge clk);
        start = 0;
        wait_done(k);
        chk("prot_sum", 32'(sum), 32'h96);
        repeat (12) @(negedge clk);
        chk("prot_ndone", 32'(dn_cnt - d0), 1);

        // Asynchronous reset in the middle of SHIFT
        a = 8'h5A; b = 8'h3C; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        #1 rst_n = 0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_sum", 32'(sum), 0);
        chk("arst_co", 32'(co), 0);
        chk("arst_ovf", 32'(ovf), 0);
        chk("arst_done", 32'(done), 0);
        d0 = dn_cnt;
        @(negedge clk);
        rst_n = 1;
        repeat (12) @(negedge clk);
        chk("arst_nodone", 32'(dn_cnt - d0), 0);
        do_op(8'h03, 8'h04, 0, 0, 8'h07, 0, 0, "post_rst");

        // Back-to-back with start held high
        a = 8'h01; b = 8'h01; ci = 0; sub = 0; start = 1;
        wait_done(k);
        c1 = cyc;
        chk("b2b_sum1", 32'(sum), 32'h02);
        a = 8'h7F; b = 8'h01;
        repeat (5) @(negedge clk);
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_hold", 32'(sum), 32'h02);
        wait_done(k);
        chk("b2b_gap", 32'(cyc - c1), 32'd10);
        start = 0;
        chk("b2b_sum2", 32'(sum), 32'h80);
        chk("b2b_ovf2", 32'(ovf), 1);
        chk("b2b_co2", 32'(co), 0);
        repeat (3) @(negedge clk);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a = W'($urandom);
            b = W'($urandom);
            ci = 1'($urandom);
            sub = 1'($urandom);
        end
        start = 0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
